// File: rtl/mod_counter_if.sv
// Bus bundle for mod_counter: control inputs, limit/load values and count outputs.
// o_bcd is present only when COUNTER_BCD_EN is defined.
interface mod_counter_if #(
  parameter int WIDTH = 6
);
  logic             i_en;
  logic             i_up;
  logic             i_clr;
  logic             i_load;
  logic [WIDTH-1:0] i_load_val;
  logic [WIDTH-1:0] i_limit;
  logic [WIDTH-1:0] o_count;
  logic             o_carry;
`ifdef COUNTER_BCD_EN
  logic [7:0]       o_bcd;

  modport master (
    output i_en, i_up, i_clr, i_load, i_load_val, i_limit,
    input  o_count, o_carry, o_bcd
  );
  modport slave (
    input  i_en, i_up, i_clr, i_load, i_load_val, i_limit,
    output o_count, o_carry, o_bcd
  );
`else
  modport master (
    output i_en, i_up, i_clr, i_load, i_load_val, i_limit,
    input  o_count, o_carry
  );
  modport slave (
    input  i_en, i_up, i_clr, i_load, i_load_val, i_limit,
    output o_count, o_carry
  );
`endif
endinterface

// File: rtl/mod_counter.sv
// Modulo-N up/down time-base counter with clear, load and registered wrap pulse.
// Optional registered BCD output of the count when COUNTER_BCD_EN is defined.
module mod_counter #(
  parameter int          WIDTH   = 6,
  parameter int unsigned RST_VAL = 0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  mod_counter_if.slave bus
);
  localparam logic [WIDTH-1:0] RST_COUNT = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] limit_m1;

  // Limits of 0 and 1 collapse to a single state 0, so the top count is 0.
  always_comb begin
    limit_m1 = '0;
    if (bus.i_limit >= WIDTH'(2)) begin
      limit_m1 = bus.i_limit - WIDTH'(1);
    end
  end

  always_comb begin
    count_d = count_q;
    carry_d = 1'b0;
    if (bus.i_clr) begin
      count_d = '0;
    end else if (bus.i_load) begin
      count_d = (bus.i_load_val < bus.i_limit) ? bus.i_load_val : '0;
    end else if (bus.i_en) begin
      if (bus.i_up) begin
        if (count_q >= limit_m1) begin
          count_d = '0;
          carry_d = 1'b1;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          count_d = limit_m1;
          carry_d = 1'b1;
        end else if (count_q >= bus.i_limit) begin
          // Limit was lowered under a larger count: clamp without a borrow.
          count_d = limit_m1;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count_q <= RST_COUNT;
      carry_q <= 1'b0;
    end else begin
      count_q <= count_d;
      carry_q <= carry_d;
    end
  end

  assign bus.o_count = count_q;
  assign bus.o_carry = carry_q;

`ifdef COUNTER_BCD_EN
  function automatic logic [7:0] to_bcd(input logic [15:0] v);
    logic [6:0] b;
    logic [3:0] tens;
    logic [3:0] ones;
    if (v > 16'd99) begin
      return 8'h99;
    end
    b    = v[6:0];
    tens = 4'(b / 7'd10);
    ones = 4'(b % 7'd10);
    return {tens, ones};
  endfunction

  logic [7:0] bcd_q, bcd_d;

  // Converted from the next count so BCD and binary change on the same edge.
  always_comb begin
    bcd_d = to_bcd(16'(count_d));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bcd_q <= to_bcd(16'(RST_COUNT));
    end else begin
      bcd_q <= bcd_d;
    end
  end

  assign bus.o_bcd = bcd_q;
`endif
endmodule

// File: tb/tb_mod_counter.sv
// Directed self-checking bench for mod_counter (WIDTH = 6, RST_VAL = 0).
module tb_mod_counter;
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  mod_counter_if #(.WIDTH(6)) bus_if ();

  mod_counter #(.WIDTH(6), .RST_VAL(0)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus_if)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic up, input logic clr, input logic load,
                       input logic [5:0] load_val, input logic [5:0] limit);
    bus_if.i_en       = en;
    bus_if.i_up       = up;
    bus_if.i_clr      = clr;
    bus_if.i_load     = load;
    bus_if.i_load_val = load_val;
    bus_if.i_limit    = limit;
  endtask

  initial begin
    int exp_cnt;

    // Reset state
    drive(1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 6'd60);
    #3;
    check("rst_count", 32'(bus_if.o_count), 32'd0);
    check("rst_carry", 32'(bus_if.o_carry), 32'd0);
`ifdef COUNTER_BCD_EN
    check("rst_bcd", 32'(bus_if.o_bcd), 32'h00);
`endif
    tick();
    tick();
    i_rst = 1'b0;

    // Up count mod 60 for two full periods
    drive(1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 6'd60);
    for (int i = 1; i <= 120; i++) begin
      tick();
      exp_cnt = i % 60;
      check($sformatf("up60_count_%0d", i), 32'(bus_if.o_count), 32'(exp_cnt));
      check($sformatf("up60_carry_%0d", i), 32'(bus_if.o_carry), (exp_cnt == 0) ? 32'd1 : 32'd0);
    end

    // Down count mod 24 from 0
    drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 6'd24);
    tick();
    check("dn24_count_a", 32'(bus_if.o_count), 32'd23);
    check("dn24_carry_a", 32'(bus_if.o_carry), 32'd1);
    tick();
    check("dn24_count_b", 32'(bus_if.o_count), 32'd22);
    check("dn24_carry_b", 32'(bus_if.o_carry), 32'd0);

    // Load beats enable; out-of-range load gives 0; clear beats load
    drive(1'b1, 1'b1, 1'b0, 1'b1, 6'd45, 6'd60);
    tick();
    check("load45_count", 32'(bus_if.o_count), 32'd45);
    check("load45_carry", 32'(bus_if.o_carry), 32'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 6'd61, 6'd60);
    tick();
    check("load61_count", 32'(bus_if.o_count), 32'd0);
    check("load61_carry", 32'(bus_if.o_carry), 32'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 6'd45, 6'd60);
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 6'd45, 6'd60);
    tick();
    check("clrload_count", 32'(bus_if.o_count), 32'd0);
    check("clrload_carry", 32'(bus_if.o_carry), 32'd0);

    // Clear at the top count suppresses the wrap carry
    drive(1'b1, 1'b1, 1'b0, 1'b1, 6'd59, 6'd60);
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 6'd60);
    tick();
    check("clr59_count", 32'(bus_if.o_count), 32'd0);
    check("clr59_carry", 32'(bus_if.o_carry), 32'd0);

    // Hold
    drive(1'b0, 1'b1, 1'b0, 1'b1, 6'd10, 6'd60);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 6'd60);
    tick();
    check("hold_count", 32'(bus_if.o_count), 32'd10);
    check("hold_carry", 32'(bus_if.o_carry), 32'd0);

    // Limit lowered below count: up wraps with carry
    drive(1'b0, 1'b1, 1'b0, 1'b1, 6'd50, 6'd60);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 6'd30);
    tick();
    check("lower_up_count", 32'(bus_if.o_count), 32'd0);
    check("lower_up_carry", 32'(bus_if.o_carry), 32'd1);

    // Limit lowered below count: down clamps without borrow
    drive(1'b0, 1'b1, 1'b0, 1'b1, 6'd50, 6'd60);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 6'd30);
    tick();
    check("lower_dn_count", 32'(bus_if.o_count), 32'd29);
    check("lower_dn_carry", 32'(bus_if.o_carry), 32'd0);

    // Divide-by-1: carry follows enable one cycle later
    drive(1'b1, 1'b1, 1'b0, 1'b1, 6'd0, 6'd1);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 6'd1);
    tick();
    check("lim1_up_count", 32'(bus_if.o_count), 32'd0);
    check("lim1_up_carry", 32'(bus_if.o_carry), 32'd1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 6'd1);
    tick();
    check("lim1_idle_count", 32'(bus_if.o_count), 32'd0);
    check("lim1_idle_carry", 32'(bus_if.o_carry), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 6'd1);
    tick();
    check("lim1_dn_count", 32'(bus_if.o_count), 32'd0);
    check("lim1_dn_carry", 32'(bus_if.o_carry), 32'd1);

    // Asynchronous reset between edges at count 37
    drive(1'b0, 1'b1, 1'b0, 1'b1, 6'd36, 6'd60);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 6'd60);
    tick();
    check("pre_rst_count", 32'(bus_if.o_count), 32'd37);
    #2;
    i_rst = 1'b1;
    #1;
    check("async_rst_count", 32'(bus_if.o_count), 32'd0);
    check("async_rst_carry", 32'(bus_if.o_carry), 32'd0);
    tick();
    check("rst_held_count", 32'(bus_if.o_count), 32'd0);
    i_rst = 1'b0;
    tick();
    check("post_rst_count", 32'(bus_if.o_count), 32'd1);
    check("post_rst_carry", 32'(bus_if.o_carry), 32'd0);

`ifdef COUNTER_BCD_EN
    // BCD tracks the count on the same edge
    drive(1'b0, 1'b1, 1'b0, 1'b1, 6'd59, 6'd60);
    tick();
    check("bcd59", 32'(bus_if.o_bcd), 32'h59);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 6'd60);
    tick();
    check("bcd_wrap", 32'(bus_if.o_bcd), 32'h00);
    check("bcd_wrap_carry", 32'(bus_if.o_carry), 32'd1);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 6'd7, 6'd60);
    tick();
    check("bcd07", 32'(bus_if.o_bcd), 32'h07);
    check("bcd07_count", 32'(bus_if.o_count), 32'd7);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mod_counter.md
Name: mod_counter

Overview:
- Parametrised modulo-N time-base counter; generalises the fixed 6-bit up-counter.
- Adds configurable width, up/down direction, count enable, synchronous clear, parallel load and a registered carry/borrow pulse.
- Multiple instances cascade (o_carry -> next stage i_en) to build seconds/minutes/hours chains and time-set logic in the clock datapath.

Parameters:
- WIDTH, 6, bit width of count, limit and load value (2..16).
- RST_VAL, 0, o_count value on reset; must be < i_limit in use.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  asynchronous reset, active-high.
- i_en  input  1  count enable / carry-in; one step per enabled cycle.
- i_up  input  1  direction: 1 = increment, 0 = decrement.
- i_clr  input  1  synchronous clear to 0.
- i_load  input  1  synchronous parallel load.
- i_load_val  input  WIDTH  value for load.
- i_limit  input  WIDTH  modulus N; count range 0..N-1.
- o_count  output  WIDTH  current count, registered.
- o_carry  output  1  one-cycle wrap pulse (carry up / borrow down), registered.
- o_bcd  output  8  tens/ones BCD of o_count; present only with COUNTER_BCD_EN.

Behaviour:
- Reset is asynchronous, active-high: o_count = RST_VAL, o_carry = 0, o_bcd = BCD(RST_VAL), held while i_rst = 1.
- Synchronous priority, highest first: i_clr > i_load > i_en step > hold.
- i_clr: o_count <= 0, o_carry <= 0.
- i_load: o_count <= i_load_val if i_load_val < i_limit, else 0. o_carry <= 0.
- Up step (i_en = 1, i_up = 1):
  - If o_count >= i_limit - 1: o_count <= 0, o_carry <= 1.
  - Else: o_count <= o_count + 1, o_carry <= 0.
- Down step (i_en = 1, i_up = 0):
  - If o_count == 0: o_count <= i_limit - 1, o_carry <= 1.
  - Else if o_count >= i_limit (limit lowered at runtime): o_count <= i_limit - 1, o_carry <= 0.
  - Else: o_count <= o_count - 1, o_carry <= 0.
- Hold (i_en = 0): o_count unchanged, o_carry <= 0. o_carry is never high two consecutive cycles unless i_en is high on consecutive wraps.
- Latency: o_count and o_carry update on the same edge as the wrapping step. o_carry is high during the cycle in which o_count shows the wrapped value.
- Degenerate limits: i_limit = 0 or 1 keeps o_count at 0, and every enabled step asserts o_carry (divide-by-1 passthrough, registered).
- Runtime i_limit change: takes effect on the next step. An up step with o_count >= i_limit wraps to 0 with carry.
- Arithmetic: modulo handled explicitly, with no reliance on WIDTH overflow. Comparisons are unsigned, WIDTH bits. i_limit - 1 is computed in WIDTH bits, only when i_limit >= 2.
- Reset mid-count: immediate asynchronous return to reset values. The first step after deassertion starts from RST_VAL.
- Simultaneous i_clr/i_load with i_en: the step is discarded and no carry is emitted.

Optional Feature:
- Macro: COUNTER_BCD_EN.
- Defined:
  - o_bcd port exists. It is registered and updated on the same edge as o_count: o_bcd[7:4] = tens, o_bcd[3:0] = ones, both of the next count value.
  - Values > 99 saturate to 8'h99.
  - Reset value is BCD(RST_VAL).
  - Intended for direct 7-segment decoder drive.
- Undefined: no o_bcd port, no conversion logic. All other behaviour is identical.

Test Plan:
- WIDTH = 6, i_limit = 60, i_up = 1, i_en held high from reset: o_count goes 0..59, then 0 on step 60. o_carry is high exactly in the cycle o_count = 0, once per 60 cycles.
- i_limit = 24, i_up = 0, starting at 0: first step gives o_count = 23 with o_carry = 1. The next step gives 22 with o_carry = 0.
- i_load = 1, i_load_val = 45, i_en = 1, i_limit = 60: o_count = 45, no carry. Then i_load_val = 61 gives o_count = 0, no carry. i_clr + i_load together give o_count = 0.
- o_count = 50, i_limit lowered to 30: up step gives 0 with carry. Repeat the setup with a down step: gives 29, no carry. i_limit = 1: o_count stays 0, o_carry follows i_en delayed one cycle.
- Assert i_rst asynchronously mid-count (o_count = 37, between clock edges): o_count = RST_VAL and o_carry = 0 immediately. Counting resumes from RST_VAL on the first edge after release.
- COUNTER_BCD_EN defined, i_limit = 60: o_count = 59 gives o_bcd = 8'h59. Wrap gives 8'h00. Load 7 gives 8'h07, updated the same cycle as o_count.
